// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// frame/oversampling constants used by the sampler, deserializer and checkers.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam int PRESCALE  = 8;
    localparam int DATA_BITS = 8;

    // Majority samples land on edges 3..5, so edge 6 is the first edge where
    // a bit's sample is complete; edge 7 closes the bit.
    localparam logic [2:0] SAMPLE_DONE_EDGE = 3'd6;
    localparam logic [2:0] BIT_END_EDGE     = 3'd7;
    localparam logic [3:0] START_BIT_IDX    = 4'd0;

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: detects the start bit, enables the edge/bit
// counter and strobes the sampler, deserializer and frame checkers.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS = uart_rx_pkg::DATA_BITS,
    parameter int PRESCALE  = uart_rx_pkg::PRESCALE
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [3:0] bit_cnt,
    input  logic [2:0] edge_cnt,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       cnt_enable,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       deser_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       frame_err,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] START  = ST_START;
    localparam logic [2:0] DATA   = ST_DATA;
    localparam logic [2:0] PARITY = ST_PARITY;
    localparam logic [2:0] STOP   = ST_STOP;

    localparam logic [2:0] END_EDGE  = 3'(PRESCALE - 1);
    localparam logic [2:0] DONE_EDGE = 3'(PRESCALE - 2);
    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS);

    logic [2:0] state;
    logic [2:0] next_state;
    logic       par_en_q;
    logic       par_err_q;
    logic       bit_end;
    logic       samp_done;
    logic       stop_end;
    logic       bad_frame;

    assign bit_end   = (edge_cnt == END_EDGE);
    assign samp_done = (edge_cnt == DONE_EDGE);
    assign stop_end  = (state == STOP) && bit_end;
    assign bad_frame = stp_err || par_err_q;

    // Every transition except the start detect waits for the bit's last edge,
    // so the counter always stops with edge_cnt wrapped back to 0.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!RX_IN) next_state = START;
            START:   if (bit_end) next_state = strt_glitch ? IDLE : DATA;
            DATA:    if (bit_end && (bit_cnt == LAST_BIT))
                         next_state = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) next_state = STOP;
            STOP:    if (bit_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            par_en_q   <= 1'b0;
            par_err_q  <= 1'b0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= next_state;
            data_valid <= stop_end && !bad_frame;
            frame_err  <= stop_end && bad_frame;
            if ((state == IDLE) && (next_state == START))
                par_err_q <= 1'b0;
            if ((state == PARITY) && bit_end)
                par_err_q <= par_err;
            // Parity mode is frozen per frame once the start bit is confirmed.
            if ((state == START) && bit_end && !strt_glitch)
                par_en_q <= PAR_EN;
        end
    end

    assign cnt_enable  = (state != IDLE);
    assign dat_samp_en = (state != IDLE);
    assign strt_chk_en = samp_done && (state == START);
    assign deser_en    = samp_done && (state == DATA);
    assign par_chk_en  = samp_done && (state == PARITY);
    assign stp_chk_en  = samp_done && (state == STOP);
    assign dbg_state   = state;

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Control FSM of the UART receiver. It detects the start condition on `RX_IN` and drives the `enable` input of the RX edge/bit counter. It consumes that counter's `bit_cnt`/`edge_cnt` to time the data sampler, deserializer and start/parity/stop checkers. It issues a one-cycle `data_valid` or `frame_err` per frame. It sits between the RX line input and the RX datapath, one instance per receiver.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame.
- `PRESCALE`, 8: oversampling ratio, matching the counter's 3-bit `edge_cnt`.

Ports:
- `CLK`  in  1  RX oversampling clock; single clock domain.
- `RST`  in  1  asynchronous, active-low reset.
- `RX_IN`  in  1  serial line, already synchronized; idle-high.
- `PAR_EN`  in  1  parity bit present in frame.
- `bit_cnt`  in  4  bit index from the edge/bit counter; start bit = 0.
- `edge_cnt`  in  3  oversample index within the current bit, 0..7.
- `strt_glitch`  in  1  start checker flag; valid when `edge_cnt`==7.
- `par_err`  in  1  parity checker flag; valid when `edge_cnt`==7.
- `stp_err`  in  1  stop checker flag; valid when `edge_cnt`==7.
- `cnt_enable`  out  1  counter enable.
- `dat_samp_en`  out  1  sampler enable.
- `strt_chk_en`  out  1  start checker strobe.
- `deser_en`  out  1  deserializer shift strobe.
- `par_chk_en`  out  1  parity checker strobe.
- `stp_chk_en`  out  1  stop checker strobe.
- `data_valid`  out  1  registered pulse: frame accepted.
- `frame_err`  out  1  registered pulse: parity or stop error.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `RX_IN`==0 -> START.
- START: on `edge_cnt`==7:
  - `strt_glitch` -> IDLE, silent abort with no pulse.
  - otherwise -> DATA. Latch `PAR_EN` into `par_en_q`.
- DATA: on `edge_cnt`==7 and `bit_cnt`==DATA_BITS -> PARITY if `par_en_q`, else STOP.
- PARITY: on `edge_cnt`==7 -> STOP. Latch `par_err` into `par_err_q`.
- STOP: on `edge_cnt`==7 -> IDLE.
  - If `stp_err` or `par_err_q`: pulse `frame_err`.
  - Otherwise: pulse `data_valid`.
  - `par_err_q` clears on entry to START.
- `cnt_enable` = `dat_samp_en` = (state != IDLE), combinational from state.
- Check strobes are combinational and asserted only when `edge_cnt`==6 (samples at edges 3,4,5 are complete):
  - START -> `strt_chk_en`; DATA -> `deser_en`; PARITY -> `par_chk_en`; STOP -> `stp_chk_en`.
- State changes happen only on `edge_cnt`==7, including aborts. The counter therefore stops with `edge_cnt` wrapped to 0, and the counter clears `bit_cnt` during the mandatory IDLE cycle.
- `PAR_EN` changes mid-frame have no effect until the next START.

## Timing
- Reset (async, `RST`=0): state IDLE, `par_en_q`=0, `par_err_q`=0, all outputs 0. Mid-frame reset drops `cnt_enable` immediately; no pulse is issued.
- Start detection: `RX_IN` low seen at edge k -> START from k+1, `cnt_enable`=1 from k+1. First START cycle sees `edge_cnt`=0, `bit_cnt`=0.
- Frame length with `PRESCALE`=8: 80 cycles without parity, 88 with parity, counted from the first START cycle to the cycle after the STOP `edge_cnt`==7.
- `data_valid`/`frame_err`: exactly one cycle, asserted the cycle after the STOP `edge_cnt`==7 edge, coincident with the first IDLE cycle. They are mutually exclusive.
- Back-to-back frames: a new start bit is accepted from the first IDLE cycle. At most one cycle (1/8 bit) of start latency is lost.
- `RX_IN` low during STOP does not start a frame early; it is evaluated only in IDLE.

## Structure
- Shared package `uart_rx_pkg`:
  - state enum `rx_state_t`
  - constants `PRESCALE`=8, `DATA_BITS`=8
  - `SAMPLE_DONE_EDGE`=6 and `BIT_END_EDGE`=7
  - `START_BIT_IDX`=0
- The same package is reused by the sampler, deserializer and checkers.
- Single module with no sub-modules. The edge/bit counter is instantiated beside it in the RX top, not inside.

## Test plan
- Bench: behavioural edge/bit counter model; all other inputs driven directly.
- Reset mid-DATA (`bit_cnt`=4): `RST` low -> all outputs 0 same cycle; after release, state IDLE and `cnt_enable`=0.
- Frame 0xA5, `PAR_EN`=0, flags clear: exactly 8 `deser_en` pulses at `edge_cnt`==6; `data_valid` pulses once at cycle 80 after START entry; `frame_err`=0.
- Frame with `PAR_EN`=1 and `par_err`=1 at PARITY `edge_cnt`==7: one `par_chk_en`; `frame_err` pulses once at cycle 88; `data_valid` stays 0.
- `strt_glitch`=1 at START `edge_cnt`==7: return to IDLE; no `deser_en`, `data_valid` or `frame_err`; `cnt_enable` falls on the next cycle.
- `stp_err`=1 with `PAR_EN`=0: `frame_err` pulses once at cycle 80. Then `RX_IN`=0 on the IDLE cycle -> START on the next cycle, with `bit_cnt`=0 and `edge_cnt`=0.
- `PAR_EN` toggled 1->0 during DATA of a parity frame: PARITY state is still entered; frame length remains 88 cycles.
